// File: rtl/irq_conditioner.sv
// Interrupt front-end: synchronizes and edge-detects external sources, latches pending bits,
// and dispatches one unmasked source at a time as a fixed-width intr_out pulse plus holdoff.
module irq_conditioner #(
  parameter int NUM_SRC        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PULSE_CYCLES   = 3,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  output logic               intr_out,
  output logic [7:0]         src_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  // One down-counter serves both the pulse and the holdoff phase.
  localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  state_t                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic                                  intr_d;
  logic [7:0]                            src_id_d;
  logic [NUM_SRC-1:0]                    pending_d;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_q;
  logic [NUM_SRC-1:0]                    hist_q;
  logic [NUM_SRC-1:0]                    edges;
  logic [NUM_SRC-1:0]                    eligible;
  logic [NUM_SRC-1:0]                    grant;
  logic [NUM_SRC-1:0]                    clr;
  logic [7:0]                            winner;

  // NOTE: every flop here, synchronizer included, is cleared by the async reset so a reset
  // mid-pulse leaves no stale edge history that could fire a phantom request on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value of the one before.
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edges    = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign eligible = pending & ~irq_mask;

  // Walking from the top index down leaves the lowest eligible index as the winner.
  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    winner = '0;
    grant  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner   = 8'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    intr_d   = intr_out;
    src_id_d = src_id;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = ASSERT;
          intr_d   = 1'b1;
          src_id_d = winner;
          clr      = grant;
          cnt_d    = CNT_W'(PULSE_CYCLES - 1);
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          intr_d = 1'b0;
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLDOFF;
            cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge on the dispatch edge re-arms the bit: set wins over clear.
  assign pending_d = (pending & ~clr) | edges;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      intr_out <= 1'b0;
      src_id   <= '0;
      pending  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      intr_out <= intr_d;
      src_id   <= src_id_d;
      pending  <= pending_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
